// File: rtl/disp_pkg.sv
// Shared types and helpers for the display-source selector.
package disp_pkg;

  typedef enum logic [1:0] {HOME, BROWSE, EDIT} disp_state_t;

  localparam int MAX_DW = 32;
  localparam logic [MAX_DW-1:0] BLANK_CODE = '1;

  // Bit offset of source s, digit d inside the flat source bus.
  function automatic int src_off(input int s, input int d, input int ndig, input int dw);
    return (s * ndig + d) * dw;
  endfunction

endpackage

// File: rtl/tick_counter.sv
// Modulo-N counter of tick enables with synchronous clear and a terminal pulse.
module tick_counter #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic term
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [CW-1:0] cnt;

  // Clear suppresses the terminal pulse so a higher-priority event wins.
  assign term = en && !clr && (cnt == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (en)
      cnt <= term ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/disp_src_mux.sv
// Registered display-source selector with mode stepping, idle timeout and edit blink.
module disp_src_mux
  import disp_pkg::*;
#(
  parameter int NSRC          = 4,
  parameter int NDIG          = 6,
  parameter int DW            = 4,
  parameter int BLINK_TICKS   = 500,
  parameter int TIMEOUT_TICKS = 10000,
  localparam int SW = (NSRC > 1) ? $clog2(NSRC) : 1,
  localparam int PW = (NDIG > 1) ? $clog2(NDIG) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tick,
  input  logic                     btn_mode,
  input  logic                     sel_load,
  input  logic [SW-1:0]            sel_in,
  input  logic                     edit_en,
  input  logic [PW-1:0]            edit_pos,
  input  logic [NSRC*NDIG*DW-1:0]  src_bus,
  output logic [NDIG*DW-1:0]       q,
  output logic [SW-1:0]            sel,
  output logic                     sel_changed
);

  disp_state_t        state, state_n;
  logic [SW-1:0]      sel_n;
  logic [NDIG*DW-1:0] q_n;
  logic               load_ok, accept;
  logic               to_en, to_clr, to_fire;
  logic               bl_en, bl_clr, bl_term, blink_phase;

  assign load_ok = sel_load && (int'(sel_in) < NSRC);
  assign accept  = load_ok || btn_mode;

  // Timeout only runs while browsing; any accepted selection restarts it.
  assign to_en  = tick && (state == BROWSE) && !edit_en;
  assign to_clr = (state != BROWSE) || accept;

  tick_counter #(.N(TIMEOUT_TICKS)) u_timeout (
    .clk (clk),
    .rst (rst),
    .en  (to_en),
    .clr (to_clr),
    .term(to_fire)
  );

  assign bl_en  = tick && (state == EDIT);
  assign bl_clr = (state != EDIT);

  tick_counter #(.N(BLINK_TICKS)) u_blink (
    .clk (clk),
    .rst (rst),
    .en  (bl_en),
    .clr (bl_clr),
    .term(bl_term)
  );

  always_comb begin
    sel_n = sel;
    if (load_ok)
      sel_n = sel_in;
    else if (btn_mode)
      sel_n = (sel == SW'(NSRC - 1)) ? '0 : sel + 1'b1;
    else if (to_fire)
      sel_n = '0;
  end

  always_comb begin
    state_n = state;
    if (edit_en)
      state_n = EDIT;
    else if (sel_n == '0)
      state_n = HOME;
    else
      state_n = BROWSE;
  end

  // Digit mux from the registered selection; edit_pos beyond NDIG never matches.
  always_comb begin
    q_n = '0;
    for (int d = 0; d < NDIG; d++) begin
      q_n[d*DW +: DW] = src_bus[src_off(int'(sel), d, NDIG, DW) +: DW];
      if ((state == EDIT) && blink_phase && (int'(edit_pos) == d))
        q_n[d*DW +: DW] = BLANK_CODE[DW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HOME;
      sel         <= '0;
      sel_changed <= 1'b0;
      q           <= '0;
      blink_phase <= 1'b0;
    end else begin
      state       <= state_n;
      sel         <= sel_n;
      sel_changed <= (sel_n != sel);
      q           <= q_n;
      if (state != EDIT)
        blink_phase <= 1'b0;
      else if (bl_term)
        blink_phase <= ~blink_phase;
    end
  end

endmodule

// File: tb/tb_disp_src_mux.sv
// Directed self-checking bench for disp_src_mux.
module tb_disp_src_mux;
  localparam int NSRC = 5;
  localparam int NDIG = 6;
  localparam int DW   = 4;
  localparam int BT   = 2;
  localparam int TT   = 8;
  localparam int SW   = 3;
  localparam int PW   = 3;

  logic                    clk = 1'b0;
  logic                    rst, tick, btn_mode, sel_load, edit_en;
  logic [SW-1:0]           sel_in;
  logic [PW-1:0]           edit_pos;
  logic [NSRC*NDIG*DW-1:0] src_bus;
  logic [NDIG*DW-1:0]      q;
  logic [SW-1:0]           sel;
  logic                    sel_changed;

  int errors = 0;
  int checks = 0;
  int salt   = 0;

  disp_src_mux #(
    .NSRC(NSRC), .NDIG(NDIG), .DW(DW), .BLINK_TICKS(BT), .TIMEOUT_TICKS(TT)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .btn_mode(btn_mode), .sel_load(sel_load),
    .sel_in(sel_in), .edit_en(edit_en), .edit_pos(edit_pos), .src_bus(src_bus),
    .q(q), .sel(sel), .sel_changed(sel_changed)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] srcd(input int s, input int d);
    return DW'(3 * s + d + 1 + salt);
  endfunction

  function automatic logic [NDIG*DW-1:0] qexp(input int s, input int bpos);
    logic [NDIG*DW-1:0] r;
    r = '0;
    for (int d = 0; d < NDIG; d++)
      r[d*DW +: DW] = (d == bpos) ? 4'hF : srcd(s, d);
    return r;
  endfunction

  task automatic fill();
    for (int s = 0; s < NSRC; s++)
      for (int d = 0; d < NDIG; d++)
        src_bus[(s*NDIG+d)*DW +: DW] = srcd(s, d);
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One tick pulse, then two idle cycles.
  task automatic tk();
    tick = 1'b1; cyc(); tick = 1'b0; cyc(); cyc();
  endtask

  initial begin
    rst = 1'b1; tick = 0; btn_mode = 0; sel_load = 0; sel_in = '0;
    edit_en = 0; edit_pos = '0;
    src_bus = '0;
    fill();
    cyc(); cyc();
    chk("rst_sel", 64'(sel), 0);
    chk("rst_chg", 64'(sel_changed), 0);
    chk("rst_q", 64'(q), 0);
    rst = 1'b0;
    cyc();
    chk("home_q", 64'(q), 64'(qexp(0, -1)));

    // Mode button walks all sources and wraps.
    for (int i = 0; i < NSRC; i++) begin
      btn_mode = 1'b1; cyc(); btn_mode = 1'b0;
      chk("btn_sel", 64'(sel), 64'((i + 1) % NSRC));
      chk("btn_chg_hi", 64'(sel_changed), 1);
      cyc();
      chk("btn_chg_lo", 64'(sel_changed), 0);
      chk("btn_q", 64'(q), 64'(qexp((i + 1) % NSRC, -1)));
    end

    // Direct load, invalid load, invalid load with button.
    sel_load = 1'b1; sel_in = 3'd2; cyc(); sel_load = 1'b0;
    chk("load_sel", 64'(sel), 2);
    chk("load_chg", 64'(sel_changed), 1);
    cyc();
    sel_load = 1'b1; sel_in = 3'd5; cyc(); sel_load = 1'b0;
    chk("inv_sel", 64'(sel), 2);
    chk("inv_chg", 64'(sel_changed), 0);
    sel_load = 1'b1; sel_in = 3'd7; btn_mode = 1'b1; cyc();
    sel_load = 1'b0; btn_mode = 1'b0;
    chk("inv_btn_sel", 64'(sel), 3);

    // Idle timeout back to home on the TT-th tick.
    sel_load = 1'b1; sel_in = 3'd1; cyc(); sel_load = 1'b0;
    for (int i = 0; i < TT - 1; i++) tk();
    chk("to_pre_sel", 64'(sel), 1);
    tick = 1'b1; cyc(); tick = 1'b0;
    chk("to_sel", 64'(sel), 0);
    chk("to_chg", 64'(sel_changed), 1);
    cyc(); cyc();

    // Button on the timeout tick wins and restarts the counter.
    sel_load = 1'b1; sel_in = 3'd1; cyc(); sel_load = 1'b0;
    for (int i = 0; i < TT - 1; i++) tk();
    tick = 1'b1; btn_mode = 1'b1; cyc(); tick = 1'b0; btn_mode = 1'b0;
    chk("to_btn_sel", 64'(sel), 2);
    for (int i = 0; i < TT - 1; i++) tk();
    chk("to_btn_hold", 64'(sel), 2);

    // Edit blink on digit 3; the timeout counter is one tick from firing.
    edit_en = 1'b1; edit_pos = 3'd3; cyc(); cyc();
    chk("edit_q0", 64'(q), 64'(qexp(2, -1)));
    for (int k = 1; k <= 6; k++) begin
      tk();
      chk("blink_q", 64'(q), 64'(qexp(2, ((k / 2) % 2) ? 3 : -1)));
    end
    chk("edit_no_to", 64'(sel), 2);
    edit_pos = 3'd6; cyc(); cyc();
    chk("pos_oob_q", 64'(q), 64'(qexp(2, -1)));
    edit_pos = 3'd3; cyc(); cyc();
    chk("pos_back_q", 64'(q), 64'(qexp(2, 3)));
    sel_load = 1'b1; sel_in = 3'd3; cyc(); sel_load = 1'b0; cyc();
    chk("edit_sel3_q", 64'(q), 64'(qexp(3, 3)));

    // Reset in the middle of a blank phase.
    rst = 1'b1; cyc();
    chk("mrst_sel", 64'(sel), 0);
    chk("mrst_q", 64'(q), 0);
    chk("mrst_chg", 64'(sel_changed), 0);
    rst = 1'b0; cyc();
    chk("mrst_q_src0", 64'(q), 64'(qexp(0, -1)));
    tk();
    chk("mrst_blink1", 64'(q), 64'(qexp(0, -1)));
    tk();
    chk("mrst_blink2", 64'(q), 64'(qexp(0, 3)));
    edit_en = 1'b0; cyc(); cyc();

    // Source data change reaches q in one cycle.
    salt = 5; fill(); cyc();
    chk("src_chg_q", 64'(q), 64'(qexp(0, -1)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
